// File: rtl/aq_fdsu_shift_seq.sv
// Multi-cycle right-shift sequencer driving the shared FDSU 1..8-bit shifter.
// Optional sticky accumulation is enabled by defining AQ_FDSU_SHIFT_STICKY_EN.
module aq_fdsu_shift_seq (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        shift_flush,
    input  logic        shift_req_vld,
    output logic        shift_req_rdy,
    input  logic [15:0] shift_req_frac,
    input  logic [4:0]  shift_req_amt,
    output logic        shift_rslt_vld,
    input  logic        shift_rslt_rdy,
    output logic [15:0] shift_rslt_frac,
    output logic        shift_rslt_sticky,
    output logic        shift_busy,
    output logic [15:0] frac_num_in,
    output logic [2:0]  frac_shift_cnt,
    input  logic [15:0] frac_shift_num
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] frac_q;
    logic [4:0]  rem_q;
    logic [3:0]  step;
    logic        accept;
    logic        amt_zero;
    logic        amt_big;

    // Shifts of 16 or more flush the whole fraction without using the shifter.
    assign amt_zero = (shift_req_amt == 5'd0);
    assign amt_big  = shift_req_amt[4];
    assign accept   = shift_req_rdy & shift_req_vld;
    assign step     = (rem_q > 5'd8) ? 4'd8 : rem_q[3:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (shift_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (shift_req_vld) begin
                        state_nxt = (amt_zero || amt_big) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem_q <= 5'd8) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (shift_rslt_rdy) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        shift_req_rdy  = 1'b0;
        shift_rslt_vld = 1'b0;
        shift_busy     = 1'b1;
        frac_num_in    = 16'd0;
        frac_shift_cnt = 3'd0;
        case (state)
            IDLE: begin
                shift_req_rdy = ~shift_flush;
                shift_busy    = 1'b0;
            end
            SHIFT: begin
                frac_num_in    = frac_q;
                // The shifter encodes its distance as 8 - cnt, so 8 wraps to 0.
                frac_shift_cnt = 3'(4'd8 - step);
            end
            DONE: begin
                shift_rslt_vld = 1'b1;
            end
            default: begin
                shift_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fraction and remaining-distance datapath
    // ------------------------------------------------------------------
    // NOTE: flush only redirects the FSM; frac_q keeps its value, while reset
    // clears every register so the result port reads zero afterwards.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            frac_q <= 16'd0;
            rem_q  <= 5'd0;
        end else if (!shift_flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        frac_q <= amt_big ? 16'd0 : shift_req_frac;
                        if (!amt_zero && !amt_big) begin
                            rem_q <= shift_req_amt;
                        end
                    end
                end
                SHIFT: begin
                    frac_q <= frac_shift_num;
                    rem_q  <= rem_q - {1'b0, step};
                end
                default: begin
                    frac_q <= frac_q;
                    rem_q  <= rem_q;
                end
            endcase
        end
    end

    assign shift_rslt_frac = frac_q;

`ifdef AQ_FDSU_SHIFT_STICKY_EN
    logic       sticky_q;
    logic [7:0] out_mask;

    // Mask of the low 'step' bits that fall off the end in this pass.
    always_comb begin
        out_mask = 8'd0;
        for (int i = 0; i < 8; i++) begin
            out_mask[i] = (4'(i) < step);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            sticky_q <= 1'b0;
        end else if (!shift_flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sticky_q <= amt_big ? (|shift_req_frac) : 1'b0;
                    end
                end
                SHIFT: begin
                    sticky_q <= sticky_q | (|(frac_q[7:0] & out_mask));
                end
                default: begin
                    sticky_q <= sticky_q;
                end
            endcase
        end
    end

    assign shift_rslt_sticky = sticky_q;
`else
    assign shift_rslt_sticky = 1'b0;
`endif

endmodule

// File: doc/aq_fdsu_shift_seq.md
Name: aq_fdsu_shift_seq

Overview:
Multi-cycle sequencer that drives the FDSU 16-bit right shifter, which shifts by 1..8 per pass, to perform an arbitrary right shift of 0..31 on a 16-bit fraction.
- Accumulates a sticky bit from every bit shifted out.
- Used for denormalisation of FDSU quotient/root fractions before rounding.
- Sits between the FDSU control path (request/result handshakes) and one shared shifter instance.

Parameters:
None.

Ports:
forever_cpuclk     input   1   clock
cpurst             input   1   reset; synchronous, active-high
shift_flush        input   1   synchronous abort; returns to IDLE
shift_req_vld      input   1   request valid
shift_req_rdy      output  1   request ready (high only in IDLE)
shift_req_frac     input   16  fraction to shift
shift_req_amt      input   5   right-shift amount, 0..31
shift_rslt_vld     output  1   result valid
shift_rslt_rdy     input   1   result accepted by consumer
shift_rslt_frac    output  16  shifted fraction (registered)
shift_rslt_sticky  output  1   OR of all bits shifted out (registered)
shift_busy         output  1   state != IDLE
frac_num_in        output  16  to shifter: current working fraction
frac_shift_cnt     output  3   to shifter: encodes shift = 8 - cnt (000 = 8, 111 = 1)
frac_shift_num     input   16  from shifter: shifted fraction, combinational

Behaviour:
- States: IDLE, SHIFT, DONE.
  - Registers: frac_q[15:0], rem_q[4:0], sticky_q.
  - shift_rslt_frac = frac_q; shift_rslt_sticky = sticky_q.
- Reset (cpurst = 1):
  - State = IDLE; frac_q = 0; rem_q = 0; sticky_q = 0.
  - Outputs: shift_rslt_vld = 0, shift_busy = 0, shift_req_rdy = 1, frac_shift_cnt = 0, frac_num_in = 0.
- Accept condition: IDLE and shift_req_vld, in cycle N.
  - amt == 0: frac_q = req_frac, sticky_q = 0, go DONE.
  - amt >= 16: frac_q = 0, sticky_q = |req_frac, go DONE. No shifter passes.
  - amt 1..15: frac_q = req_frac, rem_q = amt, sticky_q = 0, go SHIFT.
- SHIFT, per cycle:
  - step = min(rem_q, 8); frac_shift_cnt = 8 - step (3 LSBs); frac_num_in = frac_q.
  - frac_q <= frac_shift_num.
  - sticky_q <= sticky_q | (|(frac_q & ((1<<step)-1))).
  - rem_q <= rem_q - step.
  - If rem_q <= 8, go DONE.
- frac_num_in and frac_shift_cnt are 0 outside SHIFT.
- Latency from accept cycle N to rslt_vld:
  - N+1 for amt 0 or >= 16.
  - N+2 for amt 1..8.
  - N+3 for amt 9..15.
- DONE: shift_rslt_vld = 1; frac_q and sticky_q are held stable until shift_rslt_rdy.
  - On vld & rdy, go IDLE. The next request is accepted no earlier than the following cycle (no same-cycle turnaround).
- Handshake: shift_req_rdy = (state == IDLE) & ~shift_flush. The requester must hold frac/amt stable only in the accept cycle.
- Priority when events coincide: cpurst > shift_flush > handshake.
  - Flush in any state: next state IDLE, rslt_vld drops next cycle, result is discarded.
  - Flush in IDLE blocks acceptance in that cycle.
  - frac_q and sticky_q are not cleared by flush.
- Reset mid-operation has the same effect as flush, and also clears all registers.
- rem_q never underflows because step <= rem_q.

Optional Feature:
Macro AQ_FDSU_SHIFT_STICKY_EN.
- Defined: sticky_q is implemented as specified above.
- Undefined:
  - No sticky_q flop and no mask logic.
  - shift_rslt_sticky is tied to 0.
  - amt >= 16 still yields frac 0 in N+1.
  - All other timing is unchanged.

Test Plan:
- Reset, then idle → shift_req_rdy = 1, shift_rslt_vld = 0, shift_busy = 0, frac_shift_cnt = 0.
- frac = 16'hF00F, amt = 4, rslt_rdy = 1 → one SHIFT cycle with cnt = 3'b100; rslt_vld at N+2 with frac = 16'h0F00, sticky = 1.
- frac = 16'hF00F, amt = 12 → SHIFT cnt 3'b000 then 3'b100; vld at N+3 with frac = 16'h000F, sticky = 1.
- frac = 16'h8000, amt = 0 → vld at N+1 with frac = 16'h8000, sticky = 0. frac = 16'h0001, amt = 20 → vld at N+1 with frac = 0, sticky = 1.
- amt = 8, rslt_rdy held low 3 cycles → rslt_vld and frac (16'h00F0 for input 16'hF00F) stable, req_rdy = 0; rdy high → IDLE next cycle.
- Request amt = 12, flush asserted in the first SHIFT cycle → IDLE next cycle, no rslt_vld ever; a new request in the flush cycle is not accepted.
